// File: rtl/ppu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ppu_mem_arbiter
//
// Shares the VRAM and OAM ports between the CPU, the PPU fetch unit and the
// OAM DMA engine. The engine also acts as the DMA controller: a CPU write to
// 16'hFF46 copies DMA_LEN bytes from {page, 8'h00} on the system bus into
// OAM. Each byte takes one READ cycle and one WRITE cycle.
//
// Priorities: OAM  -> DMA > PPU > CPU
//             VRAM -> PPU > CPU
// While a DMA runs, PPU and CPU OAM reads return 8'hFF and CPU OAM writes
// are dropped. Read data is returned one cycle after the request. A
// registered grant tag per requester selects the RAM that was read. With no
// granted read in the previous cycle, the data output is 8'hFF.
//
// Optional feature (macro PPU_MODE_LOCK_EN): while the LCD is enabled, the
// CPU is locked out of VRAM in DRAW mode and out of OAM in SCAN and DRAW
// mode. This lockout applies whether or not the PPU is requesting. Without
// the macro, the CPU loses a memory only to a higher-priority requester
// that uses that memory in the same cycle.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   ppu_mode, lcd_en    PPU mode (0 HBLANK, 1 VBLANK, 2 SCAN, 3 DRAW), LCDC.7
//   cpu_*               CPU bus: addr/rd/wr/wdata in, rdata out
//   ppu_*               PPU fetch: rd/addr in, rdata out
//   vram_*              VRAM port (sync RAM, 1-cycle read latency)
//   oam_*               OAM port  (sync RAM, 1-cycle read latency)
//   dma_src_addr/dma_rd system-bus read for DMA, dma_rdata 1 cycle later
//   dma_active          high in DMA states START, READ, WRITE
// ---------------------------------------------------------------------------
module ppu_mem_arbiter #(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [12:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic [15:0] dma_src_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_rdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE} dma_state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_VRAM, TAG_OAM} tag_e;

  localparam logic [7:0]  LAST_IDX  = 8'(DMA_LEN - 1);
  localparam logic [15:0] DMA_REG   = 16'hFF46;

  dma_state_e state, state_next;
  logic [7:0] idx, idx_next;
  logic [7:0] page, page_next;
  tag_e       cpu_tag, cpu_tag_next;
  tag_e       ppu_tag, ppu_tag_next;

  // -------------------------------------------------------------------------
  // Address decode and request qualification
  // -------------------------------------------------------------------------
  logic cpu_in_vram, cpu_in_oam, ppu_in_vram, ppu_in_oam;
  logic cpu_access, cpu_read, dma_trigger;

  assign cpu_in_vram = (cpu_addr[15:13] == 3'b100);
  assign cpu_in_oam  = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < 8'hA0);
  assign ppu_in_vram = (ppu_addr[15:13] == 3'b100);
  assign ppu_in_oam  = (ppu_addr[15:8] == 8'hFE) && (ppu_addr[7:0] < 8'hA0);

  // A simultaneous read and write is a write; the read half is ignored.
  assign cpu_access  = cpu_rd | cpu_wr;
  assign cpu_read    = cpu_rd & ~cpu_wr;
  assign dma_trigger = cpu_wr && (cpu_addr == DMA_REG);

  assign dma_active  = (state != DMA_IDLE);

  logic cpu_vram_locked, cpu_oam_locked;

`ifdef PPU_MODE_LOCK_EN
  localparam logic [1:0] MODE_SCAN = 2'd2;
  localparam logic [1:0] MODE_DRAW = 2'd3;

  assign cpu_vram_locked = lcd_en && (ppu_mode == MODE_DRAW);
  assign cpu_oam_locked  = lcd_en && ((ppu_mode == MODE_SCAN) || (ppu_mode == MODE_DRAW));
`else
  // Mode inputs are only consulted by the lockout feature.
  logic mode_unused;
  assign mode_unused     = ^{ppu_mode, lcd_en};
  assign cpu_vram_locked = 1'b0;
  assign cpu_oam_locked  = 1'b0;
`endif

  logic ppu_vram_gnt, ppu_oam_gnt, cpu_vram_gnt, cpu_oam_gnt;

  assign ppu_vram_gnt = ppu_rd & ppu_in_vram;
  assign ppu_oam_gnt  = ppu_rd & ppu_in_oam & ~dma_active;
  assign cpu_vram_gnt = cpu_access & cpu_in_vram & ~ppu_vram_gnt & ~cpu_vram_locked;
  assign cpu_oam_gnt  = cpu_access & cpu_in_oam & ~dma_active & ~ppu_oam_gnt
                        & ~cpu_oam_locked;

  // -------------------------------------------------------------------------
  // DMA next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_next = state;
    idx_next   = idx;
    page_next  = page;
    unique case (state)
      DMA_IDLE:  ;
      DMA_START: begin
        state_next = DMA_READ;
        idx_next   = 8'h00;
      end
      DMA_READ:  state_next = DMA_WRITE;
      DMA_WRITE: begin
        if (idx == LAST_IDX) begin
          state_next = DMA_IDLE;
        end else begin
          state_next = DMA_READ;
          idx_next   = idx + 8'h01;
        end
      end
      default:   state_next = DMA_IDLE;
    endcase
    // A trigger restarts the transfer from whatever state the FSM is in.
    if (dma_trigger) begin
      state_next = DMA_START;
      idx_next   = 8'h00;
      page_next  = cpu_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Memory port muxing and grant tags
  // -------------------------------------------------------------------------
  always_comb begin
    vram_addr    = '0;
    vram_we      = 1'b0;
    vram_wdata   = '0;
    oam_addr     = '0;
    oam_we       = 1'b0;
    oam_wdata    = '0;
    dma_src_addr = '0;
    dma_rd       = 1'b0;
    cpu_tag_next = TAG_NONE;
    ppu_tag_next = TAG_NONE;

    if (ppu_vram_gnt) begin
      vram_addr    = ppu_addr[12:0];
      ppu_tag_next = TAG_VRAM;
    end else if (cpu_vram_gnt) begin
      vram_addr = cpu_addr[12:0];
      vram_we   = cpu_wr;
      if (cpu_wr) vram_wdata = cpu_wdata;
      if (cpu_read) cpu_tag_next = TAG_VRAM;
    end

    if (state == DMA_WRITE) begin
      oam_addr  = idx;
      oam_we    = 1'b1;
      oam_wdata = dma_rdata;
    end else if (ppu_oam_gnt) begin
      oam_addr     = ppu_addr[7:0];
      ppu_tag_next = TAG_OAM;
    end else if (cpu_oam_gnt) begin
      oam_addr = cpu_addr[7:0];
      oam_we   = cpu_wr;
      if (cpu_wr) oam_wdata = cpu_wdata;
      if (cpu_read) cpu_tag_next = TAG_OAM;
    end

    if (state == DMA_READ) begin
      dma_rd       = 1'b1;
      dma_src_addr = {page, idx};
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DMA_IDLE;
      idx     <= 8'h00;
      page    <= 8'h00;
      cpu_tag <= TAG_NONE;
      ppu_tag <= TAG_NONE;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      page    <= page_next;
      cpu_tag <= cpu_tag_next;
      ppu_tag <= ppu_tag_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read data return, one cycle after the granted request
  // -------------------------------------------------------------------------
  always_comb begin
    unique case (cpu_tag)
      TAG_VRAM: cpu_rdata = vram_rdata;
      TAG_OAM:  cpu_rdata = oam_rdata;
      default:  cpu_rdata = 8'hFF;
    endcase
    unique case (ppu_tag)
      TAG_VRAM: ppu_rdata = vram_rdata;
      TAG_OAM:  ppu_rdata = oam_rdata;
      default:  ppu_rdata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ppu_mem_arbiter
//
// Directed scoreboard bench for ppu_mem_arbiter. The stimulus process
// drives one request per cycle, 1 time unit after the rising edge. For
// each request it queues the expected observations, each tagged with the
// cycle in which it must appear. A monitor samples on every falling edge.
// It compares and retires each entry that is due. Any entry still queued
// at the end counts as a failure.
//
// VRAM and OAM are modelled as synchronous RAMs. The system bus returns
// addr[7:0] ^ addr[15:8] ^ 8'hC0. So page C0 yields the index itself,
// page D0 yields idx ^ 8'h10, and page F0 yields idx ^ 8'h30. This lets
// each transfer leave a distinct pattern in OAM.
// ---------------------------------------------------------------------------
module tb_ppu_mem_arbiter;

  localparam int DMA_LEN = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ppu_mode;
  logic        lcd_en;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata, oam_rdata;
  logic [15:0] dma_src_addr;
  logic        dma_rd;
  logic [7:0]  dma_rdata;
  logic        dma_active;

  always #5 clk = ~clk;

  ppu_mem_arbiter #(.DMA_LEN(DMA_LEN)) dut (
    .clk(clk), .rst(rst), .ppu_mode(ppu_mode), .lcd_en(lcd_en),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
    .oam_rdata(oam_rdata),
    .dma_src_addr(dma_src_addr), .dma_rd(dma_rd), .dma_rdata(dma_rdata),
    .dma_active(dma_active)
  );

  // ------------------------------------------------------------ memory models
  logic [7:0] vram_mem [8192];
  logic [7:0] oam_mem  [256];
  int         d0_reads = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    vram_rdata <= vram_mem[vram_addr];
    if (oam_we) oam_mem[oam_addr] <= oam_wdata;
    oam_rdata  <= oam_mem[oam_addr];
    dma_rdata  <= dma_rd ? (dma_src_addr[7:0] ^ dma_src_addr[15:8] ^ 8'hC0) : 8'h00;
    if (dma_rd && dma_src_addr[15:8] == 8'hD0) d0_reads <= d0_reads + 1;
    cyc <= cyc + 1;
  end

  // --------------------------------------------------------------- scoreboard
  typedef enum {
    S_CPU_RDATA, S_PPU_RDATA, S_VRAM_WE, S_OAM_WE, S_DMA_RD, S_DMA_ACTIVE,
    S_DMA_SRC, S_VRAM_MEM, S_OAM_MEM, S_D0_READS, S_BUS_IDLE
  } sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    int          due;
    logic [15:0] addr;
    logic [15:0] want;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   k;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [15:0] sample(input sel_e sel, input logic [15:0] addr);
    case (sel)
      S_CPU_RDATA:  return {8'h00, cpu_rdata};
      S_PPU_RDATA:  return {8'h00, ppu_rdata};
      S_VRAM_WE:    return {15'h0, vram_we};
      S_OAM_WE:     return {15'h0, oam_we};
      S_DMA_RD:     return {15'h0, dma_rd};
      S_DMA_ACTIVE: return {15'h0, dma_active};
      S_DMA_SRC:    return dma_src_addr;
      S_VRAM_MEM:   return {8'h00, vram_mem[addr[12:0]]};
      S_OAM_MEM:    return {8'h00, oam_mem[addr[7:0]]};
      S_D0_READS:   return 16'(d0_reads);
      default:      return 16'(vram_addr) | 16'(oam_addr) | dma_src_addr
                           | 16'(vram_wdata) | 16'(oam_wdata);
    endcase
  endfunction

  task automatic exp_at(input string name, input sel_e sel, input int due,
                        input logic [15:0] addr, input logic [15:0] want);
    exp_t e;
    e.name = name; e.sel = sel; e.due = due; e.addr = addr; e.want = want;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, sample(sb[i].sel, sb[i].addr), sb[i].want);
        sb.delete(i);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    ppu_rd = 1'b0;
    k = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin_cycle();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_addr = a; cpu_rd = 1'b1;
  endtask

  task automatic ppu_read(input logic [15:0] a);
    ppu_addr = a; ppu_rd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    rst = 1'b0; ppu_mode = 2'd0; lcd_en = 1'b1;
    cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = '0;
    ppu_rd = 0; ppu_addr = '0;

    // Reset state
    repeat (2) begin_cycle();
    exp_at("rst_cpu_rdata", S_CPU_RDATA, k, 0, 16'hFF);
    exp_at("rst_ppu_rdata", S_PPU_RDATA, k, 0, 16'hFF);
    exp_at("rst_vram_we",   S_VRAM_WE,   k, 0, 0);
    exp_at("rst_oam_we",    S_OAM_WE,    k, 0, 0);
    exp_at("rst_dma_rd",    S_DMA_RD,    k, 0, 0);
    exp_at("rst_dma_active", S_DMA_ACTIVE, k, 0, 0);
    exp_at("rst_bus_zero",  S_BUS_IDLE,  k, 0, 0);
    begin_cycle();
    rst = 1'b1;

    // CPU VRAM write then read back, then idle read data
    begin_cycle(); cpu_write(16'h8005, 8'h3C);
    exp_at("cpu_vram_we",  S_VRAM_WE,  k,     0,       1);
    exp_at("cpu_vram_mem", S_VRAM_MEM, k + 1, 16'h0005, 16'h3C);
    begin_cycle(); cpu_read(16'h8005);
    exp_at("cpu_vram_rd",  S_CPU_RDATA, k + 1, 0, 16'h3C);
    begin_cycle();
    exp_at("cpu_rdata_idle", S_CPU_RDATA, k + 1, 0, 16'hFF);

    // CPU OAM write/read and address-window boundaries
    begin_cycle(); cpu_write(16'hFE04, 8'h99);
    exp_at("cpu_oam_mem",  S_OAM_MEM, k + 1, 16'h0004, 16'h99);
    begin_cycle(); cpu_read(16'hFE04);
    exp_at("cpu_oam_rd",   S_CPU_RDATA, k + 1, 0, 16'h99);
    begin_cycle(); cpu_write(16'hA000, 8'h01);
    exp_at("a000_not_vram", S_VRAM_WE, k, 0, 0);
    begin_cycle(); cpu_write(16'hFEA0, 8'h01);
    exp_at("fea0_not_oam", S_OAM_WE, k, 0, 0);
    begin_cycle(); cpu_write(16'hFE9F, 8'h42);
    exp_at("fe9f_oam_we",  S_OAM_WE,  k,     0,        1);
    exp_at("fe9f_oam_mem", S_OAM_MEM, k + 1, 16'h009F, 16'h42);
    begin_cycle(); cpu_read(16'hFEA0);
    exp_at("fea0_rd_ff",   S_CPU_RDATA, k + 1, 0, 16'hFF);

    // Simultaneous rd+wr acts as a write
    begin_cycle(); cpu_write(16'h8001, 8'h77); cpu_rd = 1'b1;
    exp_at("rdwr_vram_we",  S_VRAM_WE,   k,     0,        1);
    exp_at("rdwr_vram_mem", S_VRAM_MEM,  k + 1, 16'h0001, 16'h77);
    exp_at("rdwr_no_rdata", S_CPU_RDATA, k + 1, 0,        16'hFF);

    // Priority: PPU over CPU on the same memory, both granted on different ones
    begin_cycle(); cpu_write(16'h9800, 8'hA7);
    begin_cycle(); ppu_read(16'h9800); cpu_read(16'h8010);
    exp_at("vram_prio_ppu", S_PPU_RDATA, k + 1, 0, 16'hA7);
    exp_at("vram_prio_cpu", S_CPU_RDATA, k + 1, 0, 16'hFF);
    begin_cycle(); ppu_read(16'h9800); cpu_write(16'h8002, 8'h11);
    exp_at("vram_prio_we",  S_VRAM_WE, k, 0, 0);
    begin_cycle(); ppu_read(16'h9800); cpu_read(16'hFE04);
    exp_at("split_ppu",     S_PPU_RDATA, k + 1, 0, 16'hA7);
    exp_at("split_cpu",     S_CPU_RDATA, k + 1, 0, 16'h99);
    begin_cycle(); ppu_read(16'hFE04); cpu_read(16'hFE00);
    exp_at("oam_prio_ppu",  S_PPU_RDATA, k + 1, 0, 16'h99);
    exp_at("oam_prio_cpu",  S_CPU_RDATA, k + 1, 0, 16'hFF);
    begin_cycle();
    exp_at("ppu_rdata_idle", S_PPU_RDATA, k + 1, 0, 16'hFF);

    // PPU-mode dependence of CPU access
    begin_cycle(); cpu_write(16'h8000, 8'h12);
`ifdef PPU_MODE_LOCK_EN
    begin_cycle(); ppu_mode = 2'd3; cpu_write(16'h8000, 8'h55);
    exp_at("lock_draw_we",   S_VRAM_WE,  k,     0,        0);
    exp_at("lock_draw_mem",  S_VRAM_MEM, k + 1, 16'h0000, 16'h12);
    begin_cycle(); ppu_mode = 2'd0; cpu_write(16'h8000, 8'h55);
    exp_at("hblank_we",      S_VRAM_WE,  k,     0,        1);
    exp_at("hblank_mem",     S_VRAM_MEM, k + 1, 16'h0000, 16'h55);
    begin_cycle(); ppu_mode = 2'd2; cpu_read(16'hFE04);
    exp_at("lock_scan_oam",  S_CPU_RDATA, k + 1, 0, 16'hFF);
    begin_cycle(); lcd_en = 1'b0; cpu_read(16'hFE04);
    exp_at("lcd_off_oam",    S_CPU_RDATA, k + 1, 0, 16'h99);
`else
    begin_cycle(); ppu_mode = 2'd3; cpu_write(16'h8000, 8'h55);
    exp_at("draw_open_we",   S_VRAM_WE,  k,     0,        1);
    exp_at("draw_open_mem",  S_VRAM_MEM, k + 1, 16'h0000, 16'h55);
    begin_cycle(); ppu_mode = 2'd2; cpu_read(16'hFE04);
    exp_at("scan_open_oam",  S_CPU_RDATA, k + 1, 0, 16'h99);
`endif
    begin_cycle(); ppu_mode = 2'd0; lcd_en = 1'b1;

    // Full DMA from page C0
    begin_cycle(); cpu_write(16'hFF46, 8'hC0);
    t = k + 1;
    exp_at("dma_active_start", S_DMA_ACTIVE, t,       0, 1);
    exp_at("dma_src_first",    S_DMA_SRC,    t + 1,   0, 16'hC000);
    exp_at("dma_active_last",  S_DMA_ACTIVE, t + 320, 0, 1);
    exp_at("dma_active_done",  S_DMA_ACTIVE, t + 321, 0, 0);
    for (int i = 0; i < DMA_LEN; i++)
      exp_at($sformatf("dma_oam_%0d", i), S_OAM_MEM, t + 321, 16'(i), 16'(i));
    wait_until(t + 10); cpu_read(16'hFE00); ppu_read(16'hFE04);
    exp_at("dma_cpu_oam_rd", S_CPU_RDATA, t + 11, 0, 16'hFF);
    exp_at("dma_ppu_oam_rd", S_PPU_RDATA, t + 11, 0, 16'hFF);
    wait_until(t + 11); cpu_write(16'hFE10, 8'hEE);
    exp_at("dma_cpu_wr_drop", S_OAM_WE, t + 11, 0, 0);
    exp_at("dma_rd_read",     S_DMA_RD, t + 11, 0, 1);
    exp_at("dma_src_idx5",    S_DMA_SRC, t + 11, 0, 16'hC005);
    wait_until(t + 322); cpu_read(16'hFE50);
    exp_at("post_dma_rd", S_CPU_RDATA, t + 323, 0, 16'h50);

    // Restart: trigger C0, then D0 fifty cycles later
    begin_cycle(); cpu_write(16'hFF46, 8'hC0);
    t1 = k + 1;
    wait_until(t1 + 49); cpu_write(16'hFF46, 8'hD0);
    t2 = k + 1;
    exp_at("rs_src_first",   S_DMA_SRC,    t2 + 1,   0, 16'hD000);
    exp_at("rs_active_old",  S_DMA_ACTIVE, t1 + 321, 0, 1);
    exp_at("rs_active_last", S_DMA_ACTIVE, t2 + 320, 0, 1);
    exp_at("rs_active_done", S_DMA_ACTIVE, t2 + 321, 0, 0);
    exp_at("rs_d0_reads",    S_D0_READS,   t2 + 321, 0, 16'd160);
    exp_at("rs_oam_0",   S_OAM_MEM, t2 + 321, 16'd0,   16'h10);
    exp_at("rs_oam_1",   S_OAM_MEM, t2 + 321, 16'd1,   16'h11);
    exp_at("rs_oam_50",  S_OAM_MEM, t2 + 321, 16'd50,  16'h22);
    exp_at("rs_oam_159", S_OAM_MEM, t2 + 321, 16'd159, 16'h8F);
    wait_until(t2 + 322);

    // Reset while the engine is in READ with idx 20
    begin_cycle(); cpu_write(16'hFF46, 8'hF0);
    t = k + 1;
    wait_until(t + 41); rst = 1'b0;
    exp_at("mid_rst_active", S_DMA_ACTIVE, t + 41, 0, 0);
    for (int c = 41; c <= 44; c++)
      exp_at($sformatf("mid_rst_oam_we_%0d", c), S_OAM_WE, t + c, 0, 0);
    wait_until(t + 44); rst = 1'b1;
    wait_until(t + 45); cpu_read(16'hFE13);
    exp_at("post_rst_active", S_DMA_ACTIVE, t + 46, 0, 0);
    exp_at("post_rst_oam_we", S_OAM_WE,     t + 46, 0, 0);
    exp_at("kept_oam_0",      S_OAM_MEM,    t + 46, 16'd0,  16'h30);
    exp_at("kept_oam_19",     S_OAM_MEM,    t + 46, 16'd19, 16'h23);
    exp_at("untouched_oam_20", S_OAM_MEM,   t + 46, 16'd20, 16'h04);
    exp_at("post_rst_cpu_rd", S_CPU_RDATA,  t + 46, 0,      16'h23);
    wait_until(t + 49);

    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got never sampled, expected due at cycle %0d", sb[i].name, sb[i].due);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
